// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
//   XLEN        : datapath / address width
//   mem_state_t : data-memory handshake FSM state encoding
package mem_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DONE      = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port bundle (req/gnt/rvalid handshake).
//   req    : request valid            (master -> slave)
//   we     : 1 = store, 0 = load       (master -> slave)
//   addr   : word-aligned address      (master -> slave)
//   wdata  : store data                (master -> slave)
//   gnt    : request accepted          (slave -> master)
//   rvalid : load data valid           (slave -> master)
//   rdata  : load data                 (slave -> master)
interface mem_stage_if #(
    parameter int XLEN = mem_stage_pkg::XLEN
) ();

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_stage_dmem_fsm.sv
// Data-memory handshake sequencer for the memory stage.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : current instruction is a word load
//   store     : current instruction is a word store
//   gnt       : memory accepted the request
//   rvalid    : load data valid (only honoured while waiting for it)
//   rdata     : load data
//   req       : request valid to memory
//   we        : write enable to memory
//   load_buf  : captured load data
//   done      : access complete, instruction may leave the stage
module dmem_fsm #(
    parameter int XLEN = mem_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            store,
    input  logic            gnt,
    input  logic            rvalid,
    input  logic [XLEN-1:0] rdata,
    output logic            req,
    output logic            we,
    output logic [XLEN-1:0] load_buf,
    output logic            done
);

    import mem_stage_pkg::*;

    mem_state_t      state_q, state_d;
    logic [XLEN-1:0] load_buf_q, load_buf_d;
    logic            memop;

    assign memop = load | store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            load_buf_q <= load_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_buf_d = load_buf_q;
        case (state_q)
            IDLE: begin
                // Without gnt the request simply stays up; execute is frozen
                // by stall, so address/data are stable.
                if (memop && gnt) begin
                    state_d = load ? WAIT_RESP : DONE;
                end
            end
            WAIT_RESP: begin
                if (rvalid) begin
                    load_buf_d = rdata;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req      = memop && (state_q == IDLE);
        we       = store;
        done     = (state_q == DONE);
        load_buf = load_buf_q;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline.
//   clk, rst            : clock, asynchronous active-high reset
//   regwrite..regDF     : registered outputs of execute
//   dmem                : data-memory port (master side)
//   stall               : freeze fetch/decode/execute
//   branch_flush        : taken branch, flush younger stages
//   jal_flush           : jal/jalr, flush younger stages
//   redirect_pc         : new fetch PC
//   misalign            : ld/st address not word aligned (access done aligned)
//   regD_mem, regwrite_mem, regD_val_mem : forward path to execute
//   wb_regwrite, wb_regD, wb_val         : MEM/WB pipeline register
module mem_stage #(
    parameter int XLEN = mem_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regwrite,
    input  logic            loadF,
    input  logic            storeF,
    input  logic            jalF,
    input  logic            jalrF,
    input  logic [XLEN-1:0] target,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] store_data,
    input  logic            branch_cond,
    input  logic [4:0]      regDF,
    mem_stage_if.master     dmem,
    output logic            stall,
    output logic            branch_flush,
    output logic            jal_flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign,
    output logic [4:0]      regD_mem,
    output logic            regwrite_mem,
    output logic [XLEN-1:0] regD_val_mem,
    output logic            wb_regwrite,
    output logic [4:0]      wb_regD,
    output logic [XLEN-1:0] wb_val
);

    import mem_stage_pkg::*;

    logic            memop;
    logic            done;
    logic [XLEN-1:0] load_buf;

    logic            wb_regwrite_q, wb_regwrite_d;
    logic [4:0]      wb_regD_q, wb_regD_d;
    logic [XLEN-1:0] wb_val_q, wb_val_d;

    assign memop = loadF | storeF;

    dmem_fsm #(.XLEN(XLEN)) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .load     (loadF),
        .store    (storeF),
        .gnt      (dmem.gnt),
        .rvalid   (dmem.rvalid),
        .rdata    (dmem.rdata),
        .req      (dmem.req),
        .we       (dmem.we),
        .load_buf (load_buf),
        .done     (done)
    );

    assign dmem.addr  = {result[XLEN-1:2], 2'b00};
    assign dmem.wdata = store_data;

    always_comb begin
        stall        = memop && !done;
        // Branches and jumps are never memops, so no stall gating is needed.
        branch_flush = branch_cond;
        jal_flush    = jalF | jalrF;
        redirect_pc  = target;
        misalign     = memop && (result[1:0] != 2'b00);
        regD_mem     = regDF;
        regD_val_mem = loadF ? load_buf : result;
        // A load's value only exists once the FSM reaches DONE.
        regwrite_mem = regwrite && !(loadF && !done);
    end

    always_comb begin
        wb_regwrite_d = wb_regwrite_q;
        wb_regD_d     = wb_regD_q;
        wb_val_d      = wb_val_q;
        if (stall) begin
            // Inject a bubble into writeback; index/value hold.
            wb_regwrite_d = 1'b0;
        end else begin
            wb_regwrite_d = regwrite;
            wb_regD_d     = regDF;
            wb_val_d      = regD_val_mem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_regwrite_q <= 1'b0;
            wb_regD_q     <= '0;
            wb_val_q      <= '0;
        end else begin
            wb_regwrite_q <= wb_regwrite_d;
            wb_regD_q     <= wb_regD_d;
            wb_val_q      <= wb_val_d;
        end
    end

    assign wb_regwrite = wb_regwrite_q;
    assign wb_regD     = wb_regD_q;
    assign wb_val      = wb_val_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1 time unit after posedge,
// outputs are sampled on negedge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite, loadF, storeF, jalF, jalrF, branch_cond;
    logic [31:0] target, result, store_data;
    logic [4:0]  regDF;
    logic        stall, branch_flush, jal_flush, misalign;
    logic [31:0] redirect_pc, regD_val_mem, wb_val;
    logic [4:0]  regD_mem, wb_regD;
    logic        regwrite_mem, wb_regwrite;

    int n_chk  = 0;
    int n_pass = 0;

    mem_stage_if #(.XLEN(32)) dmem_bus ();

    mem_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .regwrite     (regwrite),
        .loadF        (loadF),
        .storeF       (storeF),
        .jalF         (jalF),
        .jalrF        (jalrF),
        .target       (target),
        .result       (result),
        .store_data   (store_data),
        .branch_cond  (branch_cond),
        .regDF        (regDF),
        .dmem         (dmem_bus),
        .stall        (stall),
        .branch_flush (branch_flush),
        .jal_flush    (jal_flush),
        .redirect_pc  (redirect_pc),
        .misalign     (misalign),
        .regD_mem     (regD_mem),
        .regwrite_mem (regwrite_mem),
        .regD_val_mem (regD_val_mem),
        .wb_regwrite  (wb_regwrite),
        .wb_regD      (wb_regD),
        .wb_val       (wb_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic nop();
        regwrite = 0; loadF = 0; storeF = 0; jalF = 0; jalrF = 0; branch_cond = 0;
        target = 0; result = 0; store_data = 0; regDF = 0;
        dmem_bus.gnt = 0; dmem_bus.rvalid = 0; dmem_bus.rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // reset state
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_bus.req), 32'd0);
        check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("rst_wb_val", wb_val, 32'd0);
        check("rst_wb_regD", 32'(wb_regD), 32'd0);

        // 1. store 0xDEADBEEF to 0x100, gnt on third request cycle
        tick();
        storeF = 1; result = 32'h100; store_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            dmem_bus.gnt = (i == 2);
            @(negedge clk);
            check($sformatf("st_req_c%0d", i), 32'(dmem_bus.req), 32'd1);
            check($sformatf("st_we_c%0d", i), 32'(dmem_bus.we), 32'd1);
            check($sformatf("st_stall_c%0d", i), 32'(stall), 32'd1);
            if (i == 0) begin
                check("st_addr", dmem_bus.addr, 32'h100);
                check("st_wdata", dmem_bus.wdata, 32'hDEADBEEF);
                check("st_misalign", 32'(misalign), 32'd0);
            end
            tick();
        end
        dmem_bus.gnt = 0;
        @(negedge clk);
        check("st_req_done", 32'(dmem_bus.req), 32'd0);
        check("st_stall_done", 32'(stall), 32'd0);
        tick();
        nop();
        @(negedge clk);
        check("st_wb_regwrite", 32'(wb_regwrite), 32'd0);

        // 2. load x5 from 0x204, gnt immediate, rvalid two cycles later
        tick();
        loadF = 1; regwrite = 1; regDF = 5; result = 32'h204; dmem_bus.gnt = 1;
        @(negedge clk);
        check("ld_req", 32'(dmem_bus.req), 32'd1);
        check("ld_we", 32'(dmem_bus.we), 32'd0);
        check("ld_addr", dmem_bus.addr, 32'h204);
        check("ld_stall_a", 32'(stall), 32'd1);
        check("ld_fwd_wr_a", 32'(regwrite_mem), 32'd0);
        tick();
        dmem_bus.gnt = 0;
        @(negedge clk);
        check("ld_req_wait", 32'(dmem_bus.req), 32'd0);
        check("ld_stall_b", 32'(stall), 32'd1);
        check("ld_wb_bubble", 32'(wb_regwrite), 32'd0);
        tick();
        dmem_bus.rvalid = 1; dmem_bus.rdata = 32'h12345678;
        @(negedge clk);
        check("ld_stall_c", 32'(stall), 32'd1);
        tick();
        dmem_bus.rvalid = 0; dmem_bus.rdata = 0;
        @(negedge clk);
        check("ld_stall_done", 32'(stall), 32'd0);
        check("ld_fwd_wr", 32'(regwrite_mem), 32'd1);
        check("ld_fwd_val", regD_val_mem, 32'h12345678);
        check("ld_fwd_rd", 32'(regD_mem), 32'd5);
        tick();
        nop();
        @(negedge clk);
        check("ld_wb_regwrite", 32'(wb_regwrite), 32'd1);
        check("ld_wb_regD", 32'(wb_regD), 32'd5);
        check("ld_wb_val", wb_val, 32'h12345678);

        // 3. taken branch
        tick();
        branch_cond = 1; target = 32'h80;
        @(negedge clk);
        check("br_flush", 32'(branch_flush), 32'd1);
        check("br_redirect", redirect_pc, 32'h80);
        check("br_stall", 32'(stall), 32'd0);
        check("br_jal_flush", 32'(jal_flush), 32'd0);

        // 4. jalr rd=1, link value 0x44, target 0x300
        tick();
        nop();
        jalrF = 1; regwrite = 1; regDF = 1; result = 32'h44; target = 32'h300;
        @(negedge clk);
        check("jalr_flush", 32'(jal_flush), 32'd1);
        check("jalr_br_flush", 32'(branch_flush), 32'd0);
        check("jalr_redirect", redirect_pc, 32'h300);
        check("jalr_fwd_val", regD_val_mem, 32'h44);
        check("jalr_fwd_wr", 32'(regwrite_mem), 32'd1);
        tick();
        nop();
        @(negedge clk);
        check("jalr_wb_val", wb_val, 32'h44);
        check("jalr_wb_regD", 32'(wb_regD), 32'd1);
        check("jalr_wb_regwrite", 32'(wb_regwrite), 32'd1);

        // 5. load granted, reset before rvalid, late rvalid afterwards
        tick();
        loadF = 1; regwrite = 1; regDF = 7; result = 32'h40; dmem_bus.gnt = 1;
        tick();
        dmem_bus.gnt = 0;
        @(negedge clk);
        check("abort_stall_wait", 32'(stall), 32'd1);
        #2;
        rst = 1;
        nop();
        @(negedge clk);
        check("abort_stall_rst", 32'(stall), 32'd0);
        check("abort_wb_regwrite_rst", 32'(wb_regwrite), 32'd0);
        tick();
        rst = 0;
        dmem_bus.rvalid = 1; dmem_bus.rdata = 32'hDEADDEAD;
        @(negedge clk);
        check("abort_req", 32'(dmem_bus.req), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        tick();
        dmem_bus.rvalid = 0; dmem_bus.rdata = 0;
        @(negedge clk);
        check("abort_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("abort_wb_val", wb_val, 32'd0);

        // 6. misaligned load at 0x102: accessed as 0x100
        tick();
        loadF = 1; regwrite = 1; regDF = 3; result = 32'h102; dmem_bus.gnt = 1;
        @(negedge clk);
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_addr", dmem_bus.addr, 32'h100);
        check("mis_req_idle", 32'(dmem_bus.req), 32'd1);
        check("mis_load_buf_clean", regD_val_mem, 32'd0);
        tick();
        dmem_bus.gnt = 0; dmem_bus.rvalid = 1; dmem_bus.rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("mis_stall_wait", 32'(stall), 32'd1);
        tick();
        dmem_bus.rvalid = 0; dmem_bus.rdata = 0;
        @(negedge clk);
        check("mis_stall_done", 32'(stall), 32'd0);
        check("mis_fwd_val", regD_val_mem, 32'hCAFEF00D);
        tick();
        nop();
        @(negedge clk);
        check("mis_wb_val", wb_val, 32'hCAFEF00D);
        check("mis_wb_regD", 32'(wb_regD), 32'd3);
        check("mis_misalign_clear", 32'(misalign), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
